// File: rtl/rx_word_align.sv
// rx_word_align: finds the bit offset of a training word in a raw deserialized
// stream. It searches every offset at once, confirms the hit over several
// words, then locks and watches for loss of lock. A manual mode forces the
// offset from software. The aligned word is registered (one cycle latency).
module rx_word_align #(
    parameter  int WIDTH      = 16,
    parameter  int LOCK_CNT   = 4,
    parameter  int UNLOCK_CNT = 4,
    localparam int SW         = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] pattern,
    input  logic             train_en,
    input  logic             manual_en,
    input  logic [SW-1:0]    manual_shift,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             locked,
    output logic [SW-1:0]    shift,
    output logic             lock_lost
);

    // One counter serves as the match count (VERIFY) and the miss count
    // (LOCKED), so it is sized for the larger of the two thresholds.
    localparam int CMAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] LOCK_CNT_C   = CW'(LOCK_CNT);
    localparam logic [CW-1:0] UNLOCK_CNT_C = CW'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2,
        ST_MANUAL = 2'd3
    } state_t;

    state_t             state_q,      state_d;
    logic [CW-1:0]      cnt_q,        cnt_d;
    logic [SW-1:0]      shift_q,      shift_d;
    logic [WIDTH-1:0]   prev_q,       prev_d;
    logic               prev_ok_q,    prev_ok_d;
    logic [WIDTH-1:0]   dout_q,       dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               locked_q,     locked_d;
    logic               lock_lost_q,  lock_lost_d;

    logic [2*WIDTH-1:0] cat_s;
    logic [WIDTH-1:0]   cur_aligned_s;
    logic               cur_match_s;
    logic               qual_s;
    logic [WIDTH-1:0]   match_vec_s;
    logic               hit_s;
    logic [SW-1:0]      hit_idx_s;
    logic [CW-1:0]      cnt_inc_s;

    // The current word sits above the previous one, so every offset window
    // of the combined vector is a candidate word boundary.
    assign cat_s         = {din, prev_q};
    assign cur_aligned_s = cat_s[shift_q +: WIDTH];
    assign cur_match_s   = (cur_aligned_s == pattern);
    assign qual_s        = din_valid & prev_ok_q;
    assign cnt_inc_s     = cnt_q + CW'(1);

    // Compare the pattern against every offset in parallel.
    always_comb begin
        match_vec_s = '0;
        for (int s = 0; s < WIDTH; s++) begin
            match_vec_s[s] = (cat_s[s +: WIDTH] == pattern);
        end
    end

    // Pick the lowest matching offset: scanning downward lets lower hits win.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int s = WIDTH - 1; s >= 0; s--) begin
            hit_s     = hit_s | match_vec_s[s];
            hit_idx_s = match_vec_s[s] ? SW'(s) : hit_idx_s;
        end
    end

    // State register together with all other flops of the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SEARCH;
            cnt_q        <= '0;
            shift_q      <= '0;
            prev_q       <= '0;
            prev_ok_q    <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            prev_q       <= prev_d;
            prev_ok_q    <= prev_ok_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            locked_q     <= locked_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

    // Next-state logic: manual override first, then the search/verify/lock flow.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        lock_lost_d = 1'b0;
        if (manual_en) begin
            state_d = ST_MANUAL;
            shift_d = manual_shift;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (!train_en) begin
                        cnt_d = '0;
                    end else if (qual_s && hit_s) begin
                        shift_d = hit_idx_s;
                        if (LOCK_CNT == 1) begin
                            // Single-hit lock: the counter becomes the miss
                            // count straight away, so it starts empty.
                            state_d = ST_LOCKED;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_VERIFY;
                            cnt_d   = CW'(1);
                        end
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_VERIFY: begin
                    if (!train_en) begin
                        state_d = ST_SEARCH;
                        cnt_d   = '0;
                    end else if (qual_s) begin
                        if (!cur_match_s) begin
                            state_d = ST_SEARCH;
                            cnt_d   = '0;
                        end else if (cnt_inc_s == LOCK_CNT_C) begin
                            state_d = ST_LOCKED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc_s;
                        end
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
                ST_LOCKED: begin
                    if (qual_s && train_en) begin
                        if (cur_match_s) begin
                            cnt_d = '0;
                        end else if (cnt_inc_s == UNLOCK_CNT_C) begin
                            state_d     = ST_SEARCH;
                            cnt_d       = '0;
                            lock_lost_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc_s;
                        end
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_MANUAL: begin
                    // manual_en has dropped: start a fresh search, keep offset.
                    state_d = ST_SEARCH;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = ST_SEARCH;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output and history path: runs in every state on qualified words.
    always_comb begin
        prev_d       = prev_q;
        prev_ok_d    = prev_ok_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        locked_d     = (state_d == ST_LOCKED);
        if (din_valid) begin
            prev_d    = din;
            prev_ok_d = 1'b1;
        end else begin
            prev_d    = prev_q;
            prev_ok_d = prev_ok_q;
        end
        if (qual_s) begin
            dout_d       = cur_aligned_s;
            dout_valid_d = 1'b1;
        end else begin
            dout_d       = dout_q;
            dout_valid_d = 1'b0;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign locked     = locked_q;
    assign shift      = shift_q;
    assign lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_rx_word_align.sv
// Directed bench for rx_word_align (WIDTH=16). The stream is 16'hA5C3
// repeated and delayed by 5 bits, so every raw word is 16'hB874 and the
// correct offset is 5. A "bad" word flips only raw bit 0, which lands in
// exactly one offset-5 comparison (the word in which it arrives).
module tb_rx_word_align;

    localparam logic [15:0] PAT       = 16'hA5C3;
    localparam logic [15:0] GOOD      = 16'hB874; // PAT rotated left by 5
    localparam logic [15:0] BAD       = 16'hB875; // GOOD with bit 0 flipped
    localparam logic [15:0] BAD_OUT   = 16'hADC3; // PAT with bit 11 flipped
    localparam logic [15:0] MAN11_OUT = 16'h0E97; // PAT seen at offset 11

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        din_valid;
    logic [15:0] pattern;
    logic        train_en;
    logic        manual_en;
    logic [3:0]  manual_shift;
    logic [15:0] dout;
    logic        dout_valid;
    logic        locked;
    logic [3:0]  shift;
    logic        lock_lost;

    int n_vec;
    int n_err;

    rx_word_align #(.WIDTH(16), .LOCK_CNT(4), .UNLOCK_CNT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .din_valid    (din_valid),
        .pattern      (pattern),
        .train_en     (train_en),
        .manual_en    (manual_en),
        .manual_shift (manual_shift),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .locked       (locked),
        .shift        (shift),
        .lock_lost    (lock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of input, then sample 1 ns after the rising edge.
    task automatic send(input logic v, input logic [15:0] w);
        din_valid = v;
        din       = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        send(1'b0, 16'h0000);
        rst = 1'b0;
    endtask

    logic [23:0] gap_mask;
    int          nv;
    logic        v;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; din = 16'h0000; din_valid = 1'b0; pattern = PAT;
        train_en = 1'b1; manual_en = 1'b0; manual_shift = 4'd0;

        // Reset held with random inputs: every output stays zero.
        for (int i = 0; i < 3; i++) begin
            manual_en    = 1'($urandom_range(1, 0));
            manual_shift = 4'($urandom_range(15, 0));
            train_en     = 1'($urandom_range(1, 0));
            send(1'($urandom_range(1, 0)), 16'($urandom));
            check_eq("reset_outs", {dout, dout_valid, locked, shift, lock_lost}, 32'd0);
        end
        rst = 1'b0; manual_en = 1'b0; manual_shift = 4'd0; train_en = 1'b1;

        // Lock: first word only primes history, then 4 matches lock.
        send(1'b1, GOOD);
        check_eq("first_word_no_valid", dout_valid, 1'b0);
        send(1'b1, GOOD);
        check_eq("search_shift", shift, 4'd5);
        check_eq("first_out_valid", dout_valid, 1'b1);
        check_eq("first_out_old_shift", dout, GOOD);
        check_eq("lock_after_1", locked, 1'b0);
        send(1'b1, GOOD);
        check_eq("aligned_out", dout, PAT);
        check_eq("lock_after_2", locked, 1'b0);
        send(1'b1, GOOD);
        check_eq("lock_after_3", locked, 1'b0);
        send(1'b1, GOOD);
        check_eq("lock_after_4", locked, 1'b1);
        check_eq("locked_out", dout, PAT);
        send(1'b1, GOOD);
        check_eq("locked_hold", locked, 1'b1);

        // Loss of lock: 3 misses then a hit keep lock.
        send(1'b1, BAD);
        check_eq("bad_word_out", dout, BAD_OUT);
        send(1'b1, BAD);
        send(1'b1, BAD);
        check_eq("three_miss_locked", locked, 1'b1);
        send(1'b1, GOOD);
        check_eq("miss_reset_locked", locked, 1'b1);
        check_eq("miss_reset_no_lost", lock_lost, 1'b0);
        for (int i = 0; i < 3; i++) send(1'b1, BAD);
        check_eq("three_more_locked", locked, 1'b1);
        check_eq("three_more_no_lost", lock_lost, 1'b0);
        send(1'b1, BAD);
        check_eq("unlock_locked", locked, 1'b0);
        check_eq("unlock_pulse", lock_lost, 1'b1);
        send(1'b0, BAD);
        check_eq("unlock_pulse_end", lock_lost, 1'b0);

        // Relock, then training off: misses are ignored.
        for (int i = 0; i < 3; i++) send(1'b1, GOOD);
        check_eq("relock_3", locked, 1'b0);
        send(1'b1, GOOD);
        check_eq("relock_4", locked, 1'b1);
        train_en = 1'b0;
        for (int i = 0; i < 10; i++) send(1'b1, BAD);
        check_eq("train_off_locked", locked, 1'b1);
        check_eq("train_off_no_lost", lock_lost, 1'b0);
        train_en = 1'b1;

        // Manual mode: offset 11 forced, lock dropped without a pulse.
        manual_en = 1'b1; manual_shift = 4'd11;
        send(1'b0, GOOD);
        check_eq("manual_shift", shift, 4'd11);
        check_eq("manual_unlocked", locked, 1'b0);
        check_eq("manual_no_lost", lock_lost, 1'b0);
        send(1'b1, GOOD);
        check_eq("manual_out", dout, MAN11_OUT);
        check_eq("manual_out_valid", dout_valid, 1'b1);
        manual_en = 1'b0;
        send(1'b0, GOOD);
        check_eq("manual_exit_shift", shift, 4'd11);
        send(1'b1, GOOD);
        check_eq("post_manual_out", dout, MAN11_OUT);
        check_eq("post_manual_shift", shift, 4'd5);
        for (int i = 0; i < 3; i++) send(1'b1, GOOD);
        check_eq("post_manual_lock", locked, 1'b1);

        // Verify abort: third compared word bad, relock four matches later.
        do_reset();
        send(1'b1, GOOD);
        send(1'b1, GOOD);
        send(1'b1, GOOD);
        send(1'b1, BAD);
        check_eq("abort_unlocked", locked, 1'b0);
        check_eq("abort_shift_held", shift, 4'd5);
        for (int i = 0; i < 3; i++) send(1'b1, GOOD);
        check_eq("abort_relock_3", locked, 1'b0);
        send(1'b1, GOOD);
        check_eq("abort_relock_4", locked, 1'b1);

        // Valid gaps: output sequence must match the gap-free run.
        do_reset();
        gap_mask = 24'b1011_0110_1101_0011_1011_0101;
        nv = 0;
        for (int i = 0; i < 24; i++) begin
            v = gap_mask[i];
            send(v, v ? GOOD : 16'h1234);
            if (v) nv++;
            check_eq("gap_valid", dout_valid, (v && nv >= 2) ? 1'b1 : 1'b0);
            if (v && nv >= 2) check_eq("gap_dout", dout, (nv == 2) ? GOOD : PAT);
            check_eq("gap_locked", locked, (nv >= 5) ? 1'b1 : 1'b0);
        end

        // Reset while in VERIFY clears everything on the next edge.
        do_reset();
        send(1'b1, GOOD);
        send(1'b1, GOOD);
        send(1'b1, GOOD);
        check_eq("pre_rst_shift", shift, 4'd5);
        rst = 1'b1;
        send(1'b1, GOOD);
        check_eq("mid_rst_outs", {dout, dout_valid, locked, shift, lock_lost}, 32'd0);
        rst = 1'b0;
        send(1'b1, GOOD);
        check_eq("post_rst_first_word", dout_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
